// File: rtl/nios_core_debug_pkg.sv
// Shared definitions for the debug memory-access sequencer: FSM states,
// jdo command-word bit positions and the default wait-timeout.
package nios_core_debug_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } ocimem_state_e;

    localparam int JDO_RD          = 36;
    localparam int JDO_AUTOINC     = 37;
    localparam int JDO_DATA_LSB    = 3;
    localparam int JDO_ADDR_LSB    = 2;
    localparam int TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/nios_core_nios2_gen2_cpu_debug_slave_ocimem_tmo.sv
// Wait-cycle counter: cleared when a command is accepted, advanced on each
// stalled bus cycle, and flags the stall that would reach TIMEOUT cycles.
module nios_core_nios2_gen2_cpu_debug_slave_ocimem_tmo
    import nios_core_debug_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic reset_n,
    input  logic load_i,
    input  logic count_i,
    output logic done_o
);

    localparam logic [15:0] LAST = 16'(TIMEOUT - 1);

    logic [15:0] count_q;
    logic [15:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = '0;
        end else if (count_i) begin
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Asserted during the TIMEOUT-th stalled cycle, so the strobe drops at its end.
    assign done_o = count_i && !load_i && (count_q == LAST);

endmodule

// File: rtl/nios_core_nios2_gen2_cpu_debug_slave_ocimem_seq.sv
// Debug memory-access sequencer: turns jdo commands into single Avalon-MM
// reads/writes and reports the result through MonDReg and the monitor flags.
module nios_core_nios2_gen2_cpu_debug_slave_ocimem_seq
    import nios_core_debug_pkg::*;
#(
    parameter int ADDR_W  = 30,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    output logic              avm_write,
    output logic [31:0]       avm_writedata,
    input  logic [31:0]       avm_readdata,
    input  logic              avm_waitrequest,
    output logic [31:0]       MonDReg,
    output logic [ADDR_W-1:0] MonAReg,
    output logic              monitor_ready,
    output logic              monitor_error
);

    ocimem_state_e     state_q;
    logic [ADDR_W-1:0] monAddr_q;
    logic [31:0]       monData_q;
    logic [31:0]       wrData_q;
    logic              rdStb_q;
    logic              wrStb_q;
    logic              ready_q;
    logic              error_q;
    logic              autoInc_q;
    logic              overrun_q;

    logic anyStrobe;
    logic cmdAccept;
    logic tmoDone;
    logic unusedJdo;

    assign anyStrobe = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
    assign cmdAccept = (state_q == ST_IDLE) && anyStrobe;
    assign unusedJdo = ^{jdo[35], jdo[1:0]};

    nios_core_nios2_gen2_cpu_debug_slave_ocimem_tmo #(
        .TIMEOUT (TIMEOUT)
    ) u_tmo (
        .clk     (clk),
        .reset_n (reset_n),
        .load_i  (cmdAccept),
        .count_i ((rdStb_q | wrStb_q) & avm_waitrequest),
        .done_o  (tmoDone)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            monAddr_q <= '0;
            monData_q <= '0;
            wrData_q  <= '0;
            rdStb_q   <= 1'b0;
            wrStb_q   <= 1'b0;
            ready_q   <= 1'b0;
            error_q   <= 1'b0;
            autoInc_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (take_action_ocimem_a) begin
                        monAddr_q <= jdo[JDO_ADDR_LSB +: ADDR_W];
                        autoInc_q <= jdo[JDO_AUTOINC];
                        error_q   <= 1'b0;
                        overrun_q <= 1'b0;
                        if (jdo[JDO_RD]) begin
                            state_q <= ST_READ;
                            rdStb_q <= 1'b1;
                            ready_q <= 1'b0;
                        end else begin
                            ready_q <= 1'b1;
                        end
                    end else if (take_action_ocimem_b) begin
                        wrData_q  <= jdo[JDO_DATA_LSB +: 32];
                        state_q   <= ST_WRITE;
                        wrStb_q   <= 1'b1;
                        ready_q   <= 1'b0;
                        error_q   <= 1'b0;
                        overrun_q <= 1'b0;
                    end else if (take_no_action_ocimem_a) begin
                        state_q   <= ST_READ;
                        rdStb_q   <= 1'b1;
                        ready_q   <= 1'b0;
                        error_q   <= 1'b0;
                        overrun_q <= 1'b0;
                    end
                end
                ST_READ, ST_WRITE: begin
                    // Strobes during a transfer are dropped but remembered as an overrun.
                    if (anyStrobe) begin
                        overrun_q <= 1'b1;
                    end
                    if (!avm_waitrequest) begin
                        if (state_q == ST_READ) begin
                            monData_q <= avm_readdata;
                        end
                        if (autoInc_q) begin
                            monAddr_q <= monAddr_q + ADDR_W'(1);
                        end
                        rdStb_q <= 1'b0;
                        wrStb_q <= 1'b0;
                        ready_q <= 1'b1;
                        error_q <= overrun_q | anyStrobe;
                        state_q <= ST_IDLE;
                    end else if (tmoDone) begin
                        rdStb_q <= 1'b0;
                        wrStb_q <= 1'b0;
                        ready_q <= 1'b1;
                        error_q <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    rdStb_q <= 1'b0;
                    wrStb_q <= 1'b0;
                end
            endcase
        end
    end

    assign avm_address   = monAddr_q;
    assign avm_read      = rdStb_q;
    assign avm_write     = wrStb_q;
    assign avm_writedata = wrData_q;
    assign MonDReg       = monData_q;
    assign MonAReg       = monAddr_q;
    assign monitor_ready = ready_q;
    assign monitor_error = error_q;

endmodule

// File: tb/tb_nios_core_nios2_gen2_cpu_debug_slave_ocimem_seq.sv
// Directed bench for the debug memory-access sequencer with a stalling
// Avalon slave model and a scoreboard of expected bus transactions.
module tb_nios_core_nios2_gen2_cpu_debug_slave_ocimem_seq;

    localparam int ADDR_W     = 30;
    localparam int TB_TIMEOUT = 6;

    typedef struct packed {
        logic              isWrite;
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } txn_t;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [37:0]       jdo;
    logic              take_action_ocimem_a;
    logic              take_action_ocimem_b;
    logic              take_no_action_ocimem_a;
    logic [ADDR_W-1:0] avm_address;
    logic              avm_read;
    logic              avm_write;
    logic [31:0]       avm_writedata;
    logic [31:0]       avm_readdata;
    logic              avm_waitrequest;
    logic [31:0]       MonDReg;
    logic [ADDR_W-1:0] MonAReg;
    logic              monitor_ready;
    logic              monitor_error;

    int          slaveWaits = 0;
    logic        slaveStuck = 1'b0;
    logic [31:0] slaveData  = '0;
    int          waitCnt;

    txn_t expQ[$];
    txn_t seenLog[64];
    int   seenCount  = 0;
    int   readIdx    = 0;
    int   readCycles = 0;
    int   writeCount = 0;
    int   passCount  = 0;
    int   failCount  = 0;

    nios_core_nios2_gen2_cpu_debug_slave_ocimem_seq #(
        .ADDR_W  (ADDR_W),
        .TIMEOUT (TB_TIMEOUT)
    ) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .avm_address             (avm_address),
        .avm_read                (avm_read),
        .avm_write               (avm_write),
        .avm_writedata           (avm_writedata),
        .avm_readdata            (avm_readdata),
        .avm_waitrequest         (avm_waitrequest),
        .MonDReg                 (MonDReg),
        .MonAReg                 (MonAReg),
        .monitor_ready           (monitor_ready),
        .monitor_error           (monitor_error)
    );

    always #5 clk = ~clk;

    // Slave stalls slaveWaits cycles per transfer, or forever while slaveStuck.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            waitCnt <= 0;
        end else if ((avm_read || avm_write) && avm_waitrequest) begin
            waitCnt <= waitCnt + 1;
        end else begin
            waitCnt <= 0;
        end
    end

    assign avm_waitrequest = slaveStuck || (waitCnt < slaveWaits);
    assign avm_readdata    = slaveData;

    always @(negedge clk) begin
        if (avm_read) begin
            readCycles <= readCycles + 1;
        end
        if ((avm_read || avm_write) && !avm_waitrequest && seenCount < 64) begin
            seenLog[seenCount] <= {avm_write, avm_address, (avm_write ? avm_writedata : avm_readdata)};
            seenCount <= seenCount + 1;
            if (avm_write) begin
                writeCount <= writeCount + 1;
            end
        end
    end

    function automatic logic [37:0] jdoAddr(input logic autoInc, input logic rd, input logic [ADDR_W-1:0] addr);
        logic [37:0] j;
        j = '0;
        j[37] = autoInc;
        j[36] = rd;
        j[ADDR_W+1:2] = addr;
        return j;
    endfunction

    function automatic logic [37:0] jdoData(input logic [31:0] data);
        logic [37:0] j;
        j = '0;
        j[34:3] = data;
        return j;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic a, input logic b, input logic na, input logic [37:0] j);
        take_action_ocimem_a    = a;
        take_action_ocimem_b    = b;
        take_no_action_ocimem_a = na;
        jdo                     = j;
        tick();
        take_action_ocimem_a    = 1'b0;
        take_action_ocimem_b    = 1'b0;
        take_no_action_ocimem_a = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        assert (observed === expected) begin
            passCount++;
        end else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic waitReady(input int budget, output int cycles);
        cycles = 0;
        do begin
            tick();
            cycles++;
        end while (!monitor_ready && cycles < budget);
    endtask

    task automatic drainScoreboard();
        txn_t e;
        while (expQ.size() > 0) begin
            e = expQ.pop_front();
            if (readIdx < seenCount) begin
                checkOutput("bus txn", 64'(seenLog[readIdx]), 64'(e));
                readIdx++;
            end else begin
                checkOutput("bus txn count", 64'(seenCount), 64'(readIdx + 1));
            end
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cyc;
        int rc0;
        int wc0;

        jdo                     = '0;
        take_action_ocimem_a    = 1'b0;
        take_action_ocimem_b    = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        reset_n                 = 1'b1;
        #1 reset_n = 1'b0;
        tick();
        tick();
        checkOutput("reset avm_read", 64'(avm_read), 64'(0));
        checkOutput("reset avm_write", 64'(avm_write), 64'(0));
        checkOutput("reset avm_address", 64'(avm_address), 64'(0));
        checkOutput("reset avm_writedata", 64'(avm_writedata), 64'(0));
        checkOutput("reset MonDReg", 64'(MonDReg), 64'(0));
        checkOutput("reset MonAReg", 64'(MonAReg), 64'(0));
        checkOutput("reset ready/error", 64'({monitor_ready, monitor_error}), 64'(0));
        reset_n = 1'b1;
        tick();

        $display("[TB] zero-wait read");
        slaveWaits = 0;
        slaveData  = 32'hCAFEF00D;
        expQ.push_back({1'b0, 30'h10, 32'hCAFEF00D});
        rc0 = readCycles;
        applyStimulus(1'b1, 1'b0, 1'b0, jdoAddr(1'b0, 1'b1, 30'h10));
        checkOutput("t1 avm_read high", 64'(avm_read), 64'(1));
        checkOutput("t1 avm_address", 64'(avm_address), 64'h10);
        checkOutput("t1 ready cleared", 64'(monitor_ready), 64'(0));
        tick();
        checkOutput("t1 ready", 64'(monitor_ready), 64'(1));
        checkOutput("t1 MonDReg", 64'(MonDReg), 64'hCAFEF00D);
        checkOutput("t1 error", 64'(monitor_error), 64'(0));
        checkOutput("t1 read cycles", 64'(readCycles - rc0), 64'(1));
        drainScoreboard();

        $display("[TB] auto-increment write with wrap");
        applyStimulus(1'b1, 1'b0, 1'b0, jdoAddr(1'b1, 1'b0, 30'h3FFFFFFF));
        checkOutput("t2 ready after load", 64'(monitor_ready), 64'(1));
        checkOutput("t2 MonAReg loaded", 64'(MonAReg), 64'h3FFFFFFF);
        checkOutput("t2 no read on load", 64'(avm_read), 64'(0));
        slaveWaits = 3;
        expQ.push_back({1'b1, 30'h3FFFFFFF, 32'h12345678});
        applyStimulus(1'b0, 1'b1, 1'b0, jdoData(32'h12345678));
        checkOutput("t2 avm_write high", 64'(avm_write), 64'(1));
        checkOutput("t2 avm_writedata", 64'(avm_writedata), 64'h12345678);
        checkOutput("t2 ready cleared", 64'(monitor_ready), 64'(0));
        waitReady(20, cyc);
        checkOutput("t2 ready", 64'(monitor_ready), 64'(1));
        checkOutput("t2 latency", 64'(cyc), 64'(4));
        checkOutput("t2 MonAReg wrap", 64'(MonAReg), 64'(0));
        checkOutput("t2 error", 64'(monitor_error), 64'(0));
        checkOutput("t2 write dropped", 64'(avm_write), 64'(0));
        drainScoreboard();

        $display("[TB] timeout");
        slaveStuck = 1'b1;
        slaveData  = 32'hDEADBEEF;
        rc0 = readCycles;
        applyStimulus(1'b0, 1'b0, 1'b1, '0);
        checkOutput("t3 avm_read high", 64'(avm_read), 64'(1));
        waitReady(20, cyc);
        checkOutput("t3 ready", 64'(monitor_ready), 64'(1));
        checkOutput("t3 latency", 64'(cyc), 64'(TB_TIMEOUT));
        checkOutput("t3 read cycles", 64'(readCycles - rc0), 64'(TB_TIMEOUT));
        checkOutput("t3 error", 64'(monitor_error), 64'(1));
        checkOutput("t3 MonDReg kept", 64'(MonDReg), 64'hCAFEF00D);
        checkOutput("t3 MonAReg kept", 64'(MonAReg), 64'(0));
        checkOutput("t3 read dropped", 64'(avm_read), 64'(0));
        slaveStuck = 1'b0;

        $display("[TB] overrun");
        slaveWaits = 5;
        slaveData  = 32'h0BADC0DE;
        expQ.push_back({1'b0, 30'h20, 32'h0BADC0DE});
        wc0 = writeCount;
        rc0 = readCycles;
        applyStimulus(1'b1, 1'b0, 1'b0, jdoAddr(1'b0, 1'b1, 30'h20));
        checkOutput("t4 error cleared", 64'(monitor_error), 64'(0));
        checkOutput("t4 ready cleared", 64'(monitor_ready), 64'(0));
        tick();
        applyStimulus(1'b0, 1'b1, 1'b0, jdoData(32'hFFFF0000));
        checkOutput("t4 no write", 64'(avm_write), 64'(0));
        waitReady(20, cyc);
        checkOutput("t4 ready", 64'(monitor_ready), 64'(1));
        checkOutput("t4 error", 64'(monitor_error), 64'(1));
        checkOutput("t4 MonDReg", 64'(MonDReg), 64'h0BADC0DE);
        checkOutput("t4 read cycles", 64'(readCycles - rc0), 64'(6));
        checkOutput("t4 writes", 64'(writeCount - wc0), 64'(0));
        drainScoreboard();
        slaveWaits = 0;
        slaveData  = 32'h11112222;
        expQ.push_back({1'b0, 30'h20, 32'h11112222});
        applyStimulus(1'b0, 1'b0, 1'b1, '0);
        checkOutput("t4 next clears error", 64'(monitor_error), 64'(0));
        tick();
        checkOutput("t4 next ready", 64'(monitor_ready), 64'(1));
        checkOutput("t4 next error", 64'(monitor_error), 64'(0));
        checkOutput("t4 next MonDReg", 64'(MonDReg), 64'h11112222);
        drainScoreboard();

        $display("[TB] simultaneous a and b");
        wc0 = writeCount;
        applyStimulus(1'b1, 1'b1, 1'b0, jdoAddr(1'b0, 1'b0, 30'h55));
        checkOutput("t5 no write", 64'(avm_write), 64'(0));
        checkOutput("t5 MonAReg", 64'(MonAReg), 64'h55);
        checkOutput("t5 ready/error", 64'({monitor_ready, monitor_error}), 64'b10);
        tick();
        tick();
        checkOutput("t5 writes", 64'(writeCount - wc0), 64'(0));

        $display("[TB] reset mid-read");
        slaveWaits = 5;
        applyStimulus(1'b1, 1'b0, 1'b0, jdoAddr(1'b0, 1'b1, 30'h7));
        tick();
        checkOutput("t6 read in progress", 64'(avm_read), 64'(1));
        #1 reset_n = 1'b0;
        #1;
        checkOutput("t6 async read drop", 64'(avm_read), 64'(0));
        checkOutput("t6 MonAReg", 64'(MonAReg), 64'(0));
        checkOutput("t6 MonDReg", 64'(MonDReg), 64'(0));
        checkOutput("t6 ready/error", 64'({monitor_ready, monitor_error}), 64'(0));
        tick();
        reset_n = 1'b1;
        tick();
        slaveWaits = 0;
        slaveData  = 32'h5A5A5A5A;
        expQ.push_back({1'b0, 30'h7, 32'h5A5A5A5A});
        applyStimulus(1'b1, 1'b0, 1'b0, jdoAddr(1'b0, 1'b1, 30'h7));
        tick();
        checkOutput("t6 post-reset MonDReg", 64'(MonDReg), 64'h5A5A5A5A);
        checkOutput("t6 post-reset ready/error", 64'({monitor_ready, monitor_error}), 64'b10);
        drainScoreboard();

        checkOutput("no extra bus txns", 64'(seenCount), 64'(readIdx));

        $display("%0d/%0d checks passed", passCount, passCount + failCount);
        $finish;
    end

endmodule
